// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - FP op encodings, stage record and issue legality (FPU_SQRT_EN enables sqrt)
package fpu_pkg;

  localparam logic [2:0] FC_ADD  = 3'b000;
  localparam logic [2:0] FC_SUB  = 3'b001;
  localparam logic [2:0] FC_MUL  = 3'b010;
  localparam logic [2:0] FC_DIV  = 3'b011;
  localparam logic [2:0] FC_SQRT = 3'b100;

`ifdef FPU_SQRT_EN
  localparam bit SQRT_EN = 1'b1;
`else
  localparam bit SQRT_EN = 1'b0;
`endif

  typedef struct packed {
    logic       valid;
    logic [4:0] rn;
    logic [2:0] op;
  } stage_t;

  function automatic logic fc_legal(input logic [2:0] fc);
    return (fc <= FC_DIV) || (SQRT_EN && (fc == FC_SQRT));
  endfunction

  // Ops that occupy E1 for more than one cycle.
  function automatic logic fc_iter(input logic [2:0] fc);
    return (fc == FC_DIV) || (SQRT_EN && (fc == FC_SQRT));
  endfunction

endpackage

// File: rtl/fpu_pipe_ctrl_if.sv
// rtl/fpu_pipe_ctrl_if.sv - IU <-> FPU issue and hazard-report interface
interface fpu_pipe_ctrl_if;

  logic [4:0] fd;
  logic [2:0] fc;
  logic       wf;
  logic       fasmds;
  logic       id_stall;
  logic       cancel;

  logic [4:0] e1n;
  logic [4:0] e2n;
  logic [4:0] e3n;
  logic       e1w;
  logic       e2w;
  logic       e3w;
  logic       stall_div_sqrt;
  logic [4:0] wfn;
  logic       wfwe;
  logic [2:0] e1_op;
  logic       fpu_unimp;

  modport master (
    output fd, fc, wf, fasmds, id_stall, cancel,
    input  e1n, e2n, e3n, e1w, e2w, e3w, stall_div_sqrt, wfn, wfwe, e1_op, fpu_unimp
  );

  modport slave (
    input  fd, fc, wf, fasmds, id_stall, cancel,
    output e1n, e2n, e3n, e1w, e2w, e3w, stall_div_sqrt, wfn, wfwe, e1_op, fpu_unimp
  );

endinterface

// File: rtl/fpu_iter_cnt.sv
// rtl/fpu_iter_cnt.sv - loadable down-counter; busy while nonzero
module fpu_iter_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/fpu_pipe_ctrl.sv
// rtl/fpu_pipe_ctrl.sv - FPU stage tracking E1/E2/E3/WB with div/sqrt E1 occupancy (FPU_SQRT_EN enables sqrt)
module fpu_pipe_ctrl
  import fpu_pkg::*;
#(
  parameter int DIV_CYCLES  = 8,
  parameter int SQRT_CYCLES = 12
) (
  input logic           clk,
  input logic           rst_n,
  fpu_pipe_ctrl_if.slave bus
);

  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);
  localparam logic [4:0] SQRT_LOAD = 5'(SQRT_CYCLES - 1);

  stage_t     e1, e2, e3, wb;
  logic       stall;
  logic       accept_ok;
  logic       issue;
  logic       unimp_d;
  logic       unimp_q;
  logic       iter_load;
  logic [4:0] iter_val;

  // Anything that blocks issue also suppresses the unimplemented-op report.
  assign accept_ok = bus.fasmds & ~bus.id_stall & ~bus.cancel & ~stall;
  assign issue     = accept_ok & bus.wf & fc_legal(bus.fc);
  assign unimp_d   = accept_ok & ~fc_legal(bus.fc);
  assign iter_load = issue & fc_iter(bus.fc);
  assign iter_val  = (SQRT_EN && (bus.fc == FC_SQRT)) ? SQRT_LOAD : DIV_LOAD;

  fpu_iter_cnt #(
    .W(5)
  ) u_iter_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (iter_load),
    .load_val (iter_val),
    .busy     (stall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1      <= '0;
      e2      <= '0;
      e3      <= '0;
      wb      <= '0;
      unimp_q <= 1'b0;
    end else begin
      if (!stall) begin
        e1 <= issue ? {1'b1, bus.fd, bus.fc} : '0;
        e2 <= e1;
      end else begin
        // E1 is held by the iterative op; downstream drains behind a bubble.
        e2 <= '0;
      end
      e3      <= e2;
      wb      <= e3;
      unimp_q <= unimp_d;
    end
  end

  assign bus.e1w            = e1.valid;
  assign bus.e1n            = e1.rn;
  assign bus.e1_op          = e1.op;
  assign bus.e2w            = e2.valid;
  assign bus.e2n            = e2.rn;
  assign bus.e3w            = e3.valid;
  assign bus.e3n            = e3.rn;
  assign bus.wfwe           = wb.valid;
  assign bus.wfn            = wb.rn;
  assign bus.stall_div_sqrt = stall;
  assign bus.fpu_unimp      = unimp_q;

endmodule

// File: doc/fpu_pipe_ctrl.md
Name: fpu_pipe_ctrl

Overview:
- FPU-side control that answers the IU's FP issue interface.
- Consumes fd/fc/wf/fasmds from the IU ID stage and tracks destination register number and write-enable through FPU stages E1/E2/E3 and WB.
- Drives e1n/e2n/e3n, e1w/e2w/e3w and stall_div_sqrt back to the IU for hazard and forward decisions.
- Sequences multi-cycle divide/sqrt occupancy of E1. Datapath (adder/multiplier/divider arithmetic) is excluded.

Parameters:
- DIV_CYCLES, 8, cycles a divide occupies E1 (legal 2..31)
- SQRT_CYCLES, 12, cycles a sqrt occupies E1 (legal 2..31)

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- fd  in  5  destination FPR of ID-stage FP instruction
- fc  in  3  FP op: 000 add, 001 sub, 010 mul, 011 div, 100 sqrt, others reserved
- wf  in  1  ID instruction writes an FPR
- fasmds  in  1  ID instruction is FP add/sub/mul/div/sqrt
- id_stall  in  1  OR of IU stalls (stall_lw|stall_fp|stall_lwc1|stall_swc1); blocks issue
- cancel  in  1  ID instruction cancelled (branch/interrupt); blocks issue
- e1n,e2n,e3n  out  5  destination FPR in E1/E2/E3
- e1w,e2w,e3w  out  1  stage holds a valid FPR-writing op
- stall_div_sqrt  out  1  E1 occupied by iterative op; IU must hold ID
- wfn  out  5  FPR number at FPU write-back
- wfwe  out  1  FPU write-back enable
- e1_op  out  3  fc of op in E1 (datapath mux select)
- fpu_unimp  out  1  one-cycle pulse: unsupported fc seen at issue

Behaviour:
- Reset: all outputs 0; iteration counter 0; all stage valids 0.
- Issue condition: issue = fasmds & wf & ~id_stall & ~cancel & ~stall_div_sqrt & legal(fc).
- Normal advance when stall_div_sqrt=0:
  - E1 <= {issue, fd, fc}.
  - E2 <= E1; E3 <= E2; WB <= E3.
  - Latency from issue edge to wfwe=1 is 4 cycles.
- Iterative ops (fc=011/100) on issue edge:
  - E1 loads the op.
  - Counter loads DIV_CYCLES-1 or SQRT_CYCLES-1.
  - stall_div_sqrt = (counter != 0), combinational from the counter register.
- While stall_div_sqrt=1:
  - E1 holds; counter decrements each cycle.
  - E2 receives a bubble (e2w=0); E3 and WB keep advancing.
- On the edge where the counter goes 1->0, E1 stays put. On the next edge E1 advances to E2 normally. Total E1 residency = DIV_CYCLES/SQRT_CYCLES cycles.
- No issue is accepted while stall_div_sqrt=1, even if id_stall=0. This is a defensive guard; the IU already stalls.
- Non-writing or illegal ops produce bubbles: e1w=0, e1n=0.
- Reserved fc (101..111) with fasmds=1, ~id_stall, ~cancel: fpu_unimp pulses for 1 cycle, no issue.
- cancel and id_stall together: no issue and no fpu_unimp.
- Async reset mid-iteration: counter, stages and stall clear immediately. The in-flight op is lost.
- e1_op reflects the held op throughout an iteration.

Optional Feature:
- Macro FPU_SQRT_EN.
- Defined: fc=100 is legal and iterates SQRT_CYCLES.
- Undefined: fc=100 is treated as reserved (fpu_unimp pulse, no issue); SQRT_CYCLES is unused.

Decomposition:
- Shared package fpu_pkg holds:
  - fc encodings FC_ADD..FC_SQRT
  - stage record typedef {valid, rn[4:0], op[2:0]}
  - the legal(fc) function
- One natural sub-module: fpu_iter_cnt. It holds the down-counter with load/busy and is reused by any future iterative unit.

Test Plan:
- Reset with rst_n=0 mid-run -> all outputs 0 immediately; after release with no issue they stay 0.
- Issue add fd=5 at cycle 0 -> e1w/e1n=5 at cycle 1, e2 at 2, e3 at 3, wfwe=1 with wfn=5 at cycle 4.
- Issue div fd=7 with DIV_CYCLES=8:
  - stall_div_sqrt=1 for cycles 1..7.
  - e1n=7 held through cycle 8; e2n=7 at cycle 9; wfwe at cycle 11.
  - A mul issued at cycle 1 in parallel (fasmds=1) is not accepted.
- Back-to-back mul fd=1, add fd=2, sub fd=3 with no stalls -> e1/e2/e3 show 3/2/1 at cycle 3; id_stall=1 on the add cycle inserts exactly one bubble.
- fc=110 with fasmds=1 -> fpu_unimp one-cycle pulse, e1w stays 0. With cancel=1 the same input gives no pulse.
- sqrt fd=9: with FPU_SQRT_EN, stall lasts SQRT_CYCLES-1=11 cycles; without it, fpu_unimp pulses and there is no stall.
